// File: rtl/aes_io_pkg.sv
// Shared constants and types for the AES host register bank.
//   - bus widths of the core data block and key
//   - host byte-address map (base addresses and single-byte registers)
//   - run-controller state encoding
//   - key-length codes driven on CORE_KLEN
package aes_io_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned KEY_W  = 256;
  localparam int unsigned ADDR_W = 7;

  localparam logic [ADDR_W-1:0] DATA_IN_BASE  = 7'h00;
  localparam logic [ADDR_W-1:0] DATA_OUT_BASE = 7'h10;
  localparam logic [ADDR_W-1:0] KEY_BASE      = 7'h20;
  localparam logic [ADDR_W-1:0] CTRL          = 7'h40;
  localparam logic [ADDR_W-1:0] CFG           = 7'h41;
  localparam logic [ADDR_W-1:0] STATUS        = 7'h42;
  localparam logic [ADDR_W-1:0] LAT           = 7'h43;

  localparam logic [7:0] LAT_MAX = 8'hFF;

  localparam logic [1:0] KLEN_128 = 2'b00;
  localparam logic [1:0] KLEN_192 = 2'b01;
  localparam logic [1:0] KLEN_256 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/aes_io_rdmux.sv
// Host read-data byte select over the register bank.
// Ports:
//   addr      host byte address
//   data_in   128-bit input data block
//   data_out  128-bit captured result
//   key       256-bit key
//   dir, klen control / config fields
//   busy, done, err  status bits
//   lat       last-run latency
//   rdata_c   selected byte (combinational; unmapped addresses give 0x00)
module aes_io_rdmux
  import aes_io_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic [KEY_W-1:0]  key,
  input  logic              dir,
  input  logic [1:0]        klen,
  input  logic              busy,
  input  logic              done,
  input  logic              err,
  input  logic [7:0]        lat,
  output logic [7:0]        rdata_c
);

  // 16-byte windows decode on addr[6:4], the 32-byte key window on addr[6:5]
  always_comb begin
    rdata_c = 8'h00;
    if (addr[6:4] == DATA_IN_BASE[6:4]) begin
      rdata_c = data_in[{addr[3:0], 3'b000} +: 8];
    end else if (addr[6:4] == DATA_OUT_BASE[6:4]) begin
      rdata_c = data_out[{addr[3:0], 3'b000} +: 8];
    end else if (addr[6:5] == KEY_BASE[6:5]) begin
      rdata_c = key[{addr[4:0], 3'b000} +: 8];
    end else begin
      case (addr)
        CTRL:    rdata_c = {7'd0, dir};
        CFG:     rdata_c = {6'd0, klen};
        STATUS:  rdata_c = {5'd0, err, done, busy};
        LAT:     rdata_c = lat;
        default: rdata_c = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/aes_io_regs.sv
// Byte-wide host register bank and run controller in front of the AES core.
// Ports:
//   CLK, RSTB          clock, async active-low reset
//   DIN, ADDR, WR      host bus (WR=1 write, WR=0 read)
//   START              run request, rising edge launches
//   OK                 result valid (high in DONE)
//   DOUT               registered read data
//   CORE_DIN/KEY/DIR/KLEN  parameters driven straight from the registers
//   CORE_START         one-cycle launch pulse
//   CORE_DONE, CORE_DOUT   completion pulse and result from the core
module aes_io_regs
  import aes_io_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTB,
  input  logic [7:0]        DIN,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              WR,
  input  logic              START,
  output logic              OK,
  output logic [7:0]        DOUT,
  output logic [DATA_W-1:0] CORE_DIN,
  output logic [KEY_W-1:0]  CORE_KEY,
  output logic              CORE_DIR,
  output logic [1:0]        CORE_KLEN,
  output logic              CORE_START,
  input  logic              CORE_DONE,
  input  logic [DATA_W-1:0] CORE_DOUT
);

  state_t            state;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic [KEY_W-1:0]  key;
  logic              dir;
  logic [1:0]        klen;
  logic [7:0]        lat;
  logic              err;
  logic              ok;
  logic              start_q;
  logic              core_start;
  logic [7:0]        dout;
  logic [7:0]        rdata_c;
  logic              start_edge_c;
  logic              busy_c;

  assign start_edge_c = START & ~start_q;
  assign busy_c       = (state == ST_RUN);

  aes_io_rdmux u_rdmux (
    .addr     (ADDR),
    .data_in  (data_in),
    .data_out (data_out),
    .key      (key),
    .dir      (dir),
    .klen     (klen),
    .busy     (busy_c),
    .done     (ok),
    .err      (err),
    .lat      (lat),
    .rdata_c  (rdata_c)
  );

  // Register bank, host read port and run controller
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state      <= ST_IDLE;
      data_in    <= '0;
      data_out   <= '0;
      key        <= '0;
      dir        <= 1'b0;
      klen       <= 2'b00;
      lat        <= 8'h00;
      err        <= 1'b0;
      ok         <= 1'b0;
      start_q    <= 1'b1;   // START held through reset must not look like an edge
      core_start <= 1'b0;
      dout       <= 8'h00;
    end else begin
      start_q    <= START;
      core_start <= 1'b0;

      if (!WR) begin
        dout <= rdata_c;
      end

      // Host writes; the parameter space is frozen while the core runs
      if (WR) begin
        if (busy_c && (ADDR <= CFG)) begin
          err <= 1'b1;
        end else if (ADDR[6:4] == DATA_IN_BASE[6:4]) begin
          data_in[{ADDR[3:0], 3'b000} +: 8] <= DIN;
        end else if (ADDR[6:5] == KEY_BASE[6:5]) begin
          key[{ADDR[4:0], 3'b000} +: 8] <= DIN;
        end else if (ADDR == CTRL) begin
          dir <= DIN[0];
        end else if (ADDR == CFG) begin
          klen <= DIN[1:0];
        end else if (ADDR == STATUS) begin
          err <= 1'b0;
        end
      end

      // Run control; a same-edge err set below wins over a STATUS clear above
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_edge_c) begin
            state      <= ST_RUN;
            core_start <= 1'b1;
            ok         <= 1'b0;
            lat        <= 8'h00;
          end
        end
        ST_RUN: begin
          if (start_edge_c) begin
            err <= 1'b1;
          end
          if (CORE_DONE) begin
            data_out <= CORE_DOUT;
            ok       <= 1'b1;
            state    <= ST_DONE;
          end else if (lat != LAT_MAX) begin
            lat <= lat + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign OK         = ok;
  assign DOUT       = dout;
  assign CORE_DIN   = data_in;
  assign CORE_KEY   = key;
  assign CORE_DIR   = dir;
  assign CORE_KLEN  = klen;
  assign CORE_START = core_start;

endmodule
